rs_issue_sched: RTL and testbench

//  Issue scheduler between the reservation stations and the functional units.

---
 rtl/rs_issue_sched_if.sv | 35 +++
 rtl/rs_issue_sched.sv | 137 +++++++++++++
 tb/tb_rs_issue_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_sched_if.sv
// Issue-scheduler bus: RS entry status and FU status in, per-entry grants and
// scheduler occupancy out. clock/reset stay plain module ports.
interface rs_issue_sched_if #(
   parameter int NUM_RS     = 6,
   parameter int ROB_TAG_W  = 5,
   parameter int MULT_DEPTH = 4
);
   localparam int CNT_W = $clog2(MULT_DEPTH + 1);

   logic                          squash;
   logic [ROB_TAG_W-1:0]          rob_head;
   logic [NUM_RS-1:0]             entry_valid;
   logic [NUM_RS-1:0]             entry_ready;
   logic [2*NUM_RS-1:0]           entry_fu;
   logic [ROB_TAG_W*NUM_RS-1:0]   entry_rob_tag;
   logic [3:0]                    fu_ready;
   logic                          mult_done;
   logic                          load_done;
   logic [NUM_RS-1:0]             issue_grant;
   logic [3:0]                    class_grant;
   logic [CNT_W-1:0]              mult_inflight;
   logic                          load_busy;

   modport master (
      output squash, rob_head, entry_valid, entry_ready, entry_fu, entry_rob_tag,
             fu_ready, mult_done, load_done,
      input  issue_grant, class_grant, mult_inflight, load_busy
   );

   modport slave (
      input  squash, rob_head, entry_valid, entry_ready, entry_fu, entry_rob_tag,
             fu_ready, mult_done, load_done,
      output issue_grant, class_grant, mult_inflight, load_busy
   );
endinterface

// File: rtl/rs_issue_sched.sv
// Oldest-first issue scheduler: at most one grant per FU class per cycle, with
// tracking of issued entries, multiplies in flight and the single outstanding load.
module rs_issue_sched #(
   parameter int NUM_RS     = 6,
   parameter int ROB_TAG_W  = 5,
   parameter int MULT_DEPTH = 4
) (
   input logic              clock,
   input logic              reset,
   rs_issue_sched_if.slave  bus
);
   localparam int CNT_W = $clog2(MULT_DEPTH + 1);

   typedef enum logic [1:0] {
      FU_ALU   = 2'd0,
      FU_LOAD  = 2'd1,
      FU_STORE = 2'd2,
      FU_MULT  = 2'd3
   } fu_class_e;

   logic [NUM_RS-1:0]    issued_mask_q, issued_mask_d;
   logic [CNT_W-1:0]     mult_inflight_q, mult_inflight_d;
   logic                 load_busy_q, load_busy_d;

   logic [3:0]           permit;
   logic [1:0]           fu_k   [NUM_RS];
   logic [ROB_TAG_W-1:0] tag_k  [NUM_RS];
   logic [ROB_TAG_W-1:0] age_k  [NUM_RS];
   logic [NUM_RS-1:0]    eligible;

   logic [3:0]           found;
   logic [ROB_TAG_W-1:0] best_age [4];
   logic [NUM_RS-1:0]    best_oh  [4];
   logic [NUM_RS-1:0]    cls_mask [4];
   logic [NUM_RS-1:0]    grant;
   logic [3:0]           cls_grant;

   always_comb begin : elig_c
      permit           = '0;
      permit[FU_ALU]   = 1'b1;
      permit[FU_LOAD]  = !load_busy_q;
      permit[FU_STORE] = 1'b1;
      permit[FU_MULT]  = (mult_inflight_q < CNT_W'(MULT_DEPTH));
      eligible         = '0;
      for (int k = 0; k < NUM_RS; k++) begin
         fu_k[k]  = bus.entry_fu[2*k +: 2];
         tag_k[k] = bus.entry_rob_tag[ROB_TAG_W*k +: ROB_TAG_W];
         // Modular distance from the head keeps ordering correct across tag wrap.
         age_k[k] = tag_k[k] - bus.rob_head;
         eligible[k] = bus.entry_valid[k] && bus.entry_ready[k] && !issued_mask_q[k]
                       && bus.fu_ready[fu_k[k]] && permit[fu_k[k]]
                       && ((fu_k[k] != FU_STORE) || (tag_k[k] == bus.rob_head));
      end
   end

   always_comb begin : select_c
      grant     = '0;
      cls_grant = '0;
      for (int c = 0; c < 4; c++) begin
         found[c]    = 1'b0;
         best_age[c] = '0;
         best_oh[c]  = '0;
         cls_mask[c] = '0;
         // Strict less-than leaves any tie with the lower index.
         for (int k = 0; k < NUM_RS; k++) begin
            cls_mask[c][k] = (fu_k[k] == 2'(c));
            if (eligible[k] && (fu_k[k] == 2'(c)) && (!found[c] || (age_k[k] < best_age[c]))) begin
               found[c]    = 1'b1;
               best_age[c] = age_k[k];
               best_oh[c]  = NUM_RS'(1) << k;
            end
         end
         grant = grant | best_oh[c];
      end
      if (reset || bus.squash) begin
         grant = '0;
      end
      for (int k = 0; k < NUM_RS; k++) begin
         if (grant[k]) begin
            cls_grant[fu_k[k]] = 1'b1;
         end
      end
   end

   // Deallocation beats a same-cycle grant so a reallocated entry starts unissued.
   always_comb begin : next_c
      issued_mask_d   = (issued_mask_q | grant) & bus.entry_valid;
      mult_inflight_d = mult_inflight_q;
      load_busy_d     = load_busy_q;
      if (cls_grant[FU_MULT] && !(bus.mult_done && (mult_inflight_q != '0))) begin
         mult_inflight_d = mult_inflight_q + CNT_W'(1);
      end else if (!cls_grant[FU_MULT] && bus.mult_done && (mult_inflight_q != '0)) begin
         mult_inflight_d = mult_inflight_q - CNT_W'(1);
      end
      if (cls_grant[FU_LOAD]) begin
         load_busy_d = 1'b1;
      end else if (bus.load_done) begin
         load_busy_d = 1'b0;
      end
      if (bus.squash) begin
         issued_mask_d   = '0;
         mult_inflight_d = '0;
         load_busy_d     = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         issued_mask_q   <= '0;
         mult_inflight_q <= '0;
         load_busy_q     <= 1'b0;
      end else begin
         issued_mask_q   <= issued_mask_d;
         mult_inflight_q <= mult_inflight_d;
         load_busy_q     <= load_busy_d;
      end
   end

   assign bus.issue_grant   = grant;
   assign bus.class_grant   = cls_grant;
   assign bus.mult_inflight = mult_inflight_q;
   assign bus.load_busy     = load_busy_q;

   a_grant_valid_ready: assert property (@(posedge clock) disable iff (reset)
      (grant & ~(bus.entry_valid & bus.entry_ready)) == '0);
   a_mult_bound: assert property (@(posedge clock) disable iff (reset)
      mult_inflight_q <= CNT_W'(MULT_DEPTH));
   a_mult_done_idle: assert property (@(posedge clock) disable iff (reset)
      !(bus.mult_done && (mult_inflight_q == '0)));
   a_load_done_idle: assert property (@(posedge clock) disable iff (reset)
      !(bus.load_done && !load_busy_q));

   for (genvar c = 0; c < 4; c++) begin : g_one_per_class
      a_one_grant: assert property (@(posedge clock) disable iff (reset)
         $onehot0(grant & cls_mask[c]));
   end
endmodule

// File: tb/tb_rs_issue_sched.sv
// Scoreboard bench for rs_issue_sched: directed scenarios then random traffic,
// each cycle checked against an age-sorted reference model.
module tb_rs_issue_sched;
   localparam int NUM_RS     = 6;
   localparam int ROB_TAG_W  = 5;
   localparam int MULT_DEPTH = 4;
   localparam int ROB_SIZE   = 1 << ROB_TAG_W;
   localparam int ALU = 0, LOAD = 1, STORE = 2, MULT = 3;

   logic clock = 1'b0;
   logic reset;

   rs_issue_sched_if #(.NUM_RS(NUM_RS), .ROB_TAG_W(ROB_TAG_W), .MULT_DEPTH(MULT_DEPTH)) bus ();

   rs_issue_sched #(.NUM_RS(NUM_RS), .ROB_TAG_W(ROB_TAG_W), .MULT_DEPTH(MULT_DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [NUM_RS-1:0] grant;
      logic [3:0]        cls;
      int                mult;
      bit                busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   bit   e_valid [NUM_RS];
   bit   e_ready [NUM_RS];
   int   e_fu    [NUM_RS];
   int   e_tag   [NUM_RS];
   int   head;
   bit   sq, rst_in, mdone, ldone;
   bit [3:0] fu_rdy;

   bit   m_issued [NUM_RS];
   int   m_mult;
   bit   m_load;

   function automatic int age_of(int tag);
      return (tag - head + ROB_SIZE) % ROB_SIZE;
   endfunction

   function automatic bit class_ok(int c, int k);
      case (c)
         LOAD:    return !m_load;
         STORE:   return e_tag[k] == head;
         MULT:    return m_mult < MULT_DEPTH;
         default: return 1'b1;
      endcase
   endfunction

   task automatic drive_inputs();
      reset         = rst_in;
      bus.squash    = sq;
      bus.rob_head  = ROB_TAG_W'(head);
      bus.fu_ready  = fu_rdy;
      bus.mult_done = mdone;
      bus.load_done = ldone;
      for (int k = 0; k < NUM_RS; k++) begin
         bus.entry_valid[k]                          = e_valid[k];
         bus.entry_ready[k]                          = e_ready[k];
         bus.entry_fu[2*k +: 2]                      = 2'(e_fu[k]);
         bus.entry_rob_tag[ROB_TAG_W*k +: ROB_TAG_W] = ROB_TAG_W'(e_tag[k]);
      end
   endtask

   // Drives one cycle, records what the model expects, then advances the model.
   task automatic apply_stimulus();
      exp_t e;
      int   keys[$];
      int   best[$];
      int   old_mult;
      drive_inputs();
      e.grant = '0;
      e.cls   = '0;
      e.mult  = m_mult;
      e.busy  = m_load;
      if (!rst_in && !sq) begin
         for (int c = 0; c < 4; c++) begin
            keys.delete();
            for (int k = 0; k < NUM_RS; k++) begin
               if (e_valid[k] && e_ready[k] && !m_issued[k] && e_fu[k] == c && fu_rdy[c] && class_ok(c, k))
                  keys.push_back(age_of(e_tag[k]) * NUM_RS + k);
            end
            if (keys.size() > 0) begin
               best = keys.min();
               e.grant[best[0] % NUM_RS] = 1'b1;
               e.cls[c] = 1'b1;
            end
         end
      end
      exp_q.push_back(e);
      if (rst_in || sq) begin
         foreach (m_issued[k]) m_issued[k] = 1'b0;
         m_mult = 0;
         m_load = 1'b0;
      end else begin
         for (int k = 0; k < NUM_RS; k++) m_issued[k] = e_valid[k] && (m_issued[k] || e.grant[k]);
         old_mult = m_mult;
         if (e.cls[MULT]) m_mult++;
         if (mdone && old_mult > 0) m_mult--;
         m_load = e.cls[LOAD] ? 1'b1 : (ldone ? 1'b0 : m_load);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic compare(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_output(exp_t e);
      compare("issue_grant",   int'(bus.issue_grant),   int'(e.grant));
      compare("class_grant",   int'(bus.class_grant),   int'(e.cls));
      compare("mult_inflight", int'(bus.mult_inflight), e.mult);
      compare("load_busy",     int'(bus.load_busy),     int'(e.busy));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic clear_entries();
      for (int k = 0; k < NUM_RS; k++) begin
         e_valid[k] = 0; e_ready[k] = 0; e_fu[k] = 0; e_tag[k] = 0;
      end
      sq = 0; mdone = 0; ldone = 0; fu_rdy = 4'hF; head = 0;
   endtask

   task automatic set_entry(int k, int fu, int tag);
      e_valid[k] = 1; e_ready[k] = 1; e_fu[k] = fu; e_tag[k] = tag;
   endtask

   task automatic reset_cycle();
      clear_entries();
      rst_in = 1;
      apply_stimulus();
      rst_in = 0;
   endtask

   task automatic run_cycles(int n);
      for (int i = 0; i < n; i++) apply_stimulus();
   endtask

   initial begin : driver
      clear_entries();
      rst_in = 1;
      foreach (m_issued[k]) m_issued[k] = 0;
      m_mult = 0;
      m_load = 0;
      drive_inputs();
      @(posedge clock);
      #1;
      apply_stimulus();
      rst_in = 0;

      set_entry(0, ALU, 3); set_entry(1, ALU, 1);
      run_cycles(3);

      reset_cycle();
      head = 30;
      set_entry(2, ALU, 2); set_entry(4, ALU, 31);
      run_cycles(3);

      reset_cycle();
      for (int k = 0; k < 5; k++) set_entry(k, MULT, k + 1);
      run_cycles(6);
      mdone = 1; apply_stimulus(); mdone = 0;
      run_cycles(2);

      reset_cycle();
      set_entry(0, LOAD, 2); set_entry(3, LOAD, 1);
      run_cycles(3);
      ldone = 1; apply_stimulus(); ldone = 0;
      run_cycles(2);

      reset_cycle();
      head = 5;
      set_entry(1, STORE, 7);
      run_cycles(2);
      head = 7;
      run_cycles(2);

      reset_cycle();
      set_entry(0, MULT, 1); set_entry(1, MULT, 2); set_entry(2, MULT, 3); set_entry(3, LOAD, 4);
      run_cycles(3);
      sq = 1; apply_stimulus(); sq = 0;
      run_cycles(4);

      reset_cycle();
      for (int i = 0; i < 1500; i++) begin
         for (int k = 0; k < NUM_RS; k++) begin
            if (!e_valid[k]) begin
               if ($urandom_range(3) == 0) begin
                  e_valid[k] = 1;
                  e_fu[k]    = $urandom_range(3);
                  e_tag[k]   = $urandom_range(ROB_SIZE - 1);
                  e_ready[k] = $urandom_range(1);
               end
            end else if ($urandom_range(7) == 0) begin
               e_valid[k] = 0;
            end else if (!e_ready[k] && $urandom_range(2) == 0) begin
               e_ready[k] = 1;
            end
         end
         if ($urandom_range(3) == 0) head = (head + 1) % ROB_SIZE;
         if ($urandom_range(4) == 0) begin
            for (int k = 0; k < NUM_RS; k++)
               if (e_valid[k] && e_fu[k] == STORE) head = e_tag[k];
         end
         for (int c = 0; c < 4; c++) fu_rdy[c] = ($urandom_range(3) != 0);
         mdone  = (m_mult > 0) && ($urandom_range(2) == 0);
         ldone  = m_load && ($urandom_range(2) == 0);
         sq     = ($urandom_range(39) == 0);
         rst_in = ($urandom_range(149) == 0);
         apply_stimulus();
      end
      rst_in = 0;
      sq = 0;

      @(negedge clock);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
